// File: rtl/bch_pkg.sv
// Shared constants, state encoding and GF(2) helper for the BCH(14,8) encoder/decoder pair.
package bch_pkg;

  localparam int          BCH_N        = 14;
  localparam int          BCH_K        = 8;
  localparam logic [5:0]  BCH_GEN_POLY = 6'b100101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DIVIDE = 3'd1,
    CHECK  = 3'd2,
    SEARCH = 3'd3,
    DONE   = 3'd4
  } bch_dec_state_e;

  // (r*x + b) mod g(x); with b = 0 this is multiplication by x in GF(2)[x]/g(x)
  function automatic logic [4:0] bch_mulx_mod(input logic [4:0] r, input logic b);
    bch_mulx_mod = {r[3:0], b} ^ (r[4] ? BCH_GEN_POLY[4:0] : 5'b00000);
  endfunction

endpackage

// File: rtl/bch_lfsr_div.sv
// Bit-serial polynomial divider by g(x): remainder LFSR plus quotient shift register.
module bch_lfsr_div
  import bch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [4:0] rem,
  output logic [8:0] quo
);

  // remainder/quotient update, one dividend bit per enabled cycle, MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= 5'd0;
      quo <= 9'd0;
    end else if (clr) begin
      rem <= 5'd0;
      quo <= 9'd0;
    end else if (en) begin
      rem <= bch_mulx_mod(rem, bit_in);
      quo <= {quo[7:0], rem[4]};
    end
  end

endmodule

// File: rtl/bch_decoder.sv
// Serial BCH(14,8) decoder: divide, check syndrome, search single-error position, re-divide.
module bch_decoder
  import bch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BCH_N-1:0]     in_codeword,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BCH_K-1:0]     out_data,
  output logic                 out_corrected,
  output logic                 out_uncorrectable,
  output logic [3:0]           out_err_pos
);

  bch_dec_state_e   state_r, state_s;
  logic [BCH_N-1:0] cw_r;
  logic [3:0]       cnt_r;
  logic [4:0]       cand_r;
  logic [3:0]       idx_r;
  logic             corrected_r;
  logic [3:0]       pos_r;
  logic             clr_s;
  logic             en_s;
  logic [4:0]       rem_s;
  logic [8:0]       quo_s;
  logic             valid_r;
  logic [BCH_K-1:0] data_r;
  logic             corr_out_r;
  logic             unc_out_r;
  logic [3:0]       pos_out_r;

  bch_lfsr_div u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_s),
    .en     (en_s),
    .bit_in (cw_r[cnt_r]),
    .rem    (rem_s),
    .quo    (quo_s)
  );

  assign in_ready          = (state_r == IDLE);
  assign out_valid         = valid_r;
  assign out_data          = data_r;
  assign out_corrected     = corr_out_r;
  assign out_uncorrectable = unc_out_r;
  assign out_err_pos       = pos_out_r;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state and divider control
  always_comb begin
    state_s = state_r;
    clr_s   = 1'b0;
    en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = DIVIDE;
          clr_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      DIVIDE: begin
        en_s = 1'b1;
        if (cnt_r == 4'd0) begin
          state_s = CHECK;
        end else begin
          state_s = DIVIDE;
        end
      end
      CHECK: begin
        if (rem_s == 5'd0) begin
          state_s = DONE;
        end else if (!corrected_r) begin
          state_s = SEARCH;
        end else begin
          state_s = DONE;
        end
      end
      SEARCH: begin
        if (cand_r == rem_s) begin
          state_s = DIVIDE;
          clr_s   = 1'b1;
        end else if (idx_r == 4'(BCH_N - 1)) begin
          state_s = DONE;
        end else begin
          state_s = SEARCH;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // datapath: codeword, bit counter, search candidate and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_r        <= 14'd0;
      cnt_r       <= 4'd0;
      cand_r      <= 5'd0;
      idx_r       <= 4'd0;
      corrected_r <= 1'b0;
      pos_r       <= 4'd0;
      valid_r     <= 1'b0;
      data_r      <= 8'd0;
      corr_out_r  <= 1'b0;
      unc_out_r   <= 1'b0;
      pos_out_r   <= 4'd0;
    end else begin
      valid_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            cw_r        <= in_codeword;
            cnt_r       <= 4'(BCH_N - 1);
            corrected_r <= 1'b0;
            pos_r       <= 4'd0;
          end
        end
        DIVIDE: begin
          cnt_r <= cnt_r - 4'd1;
        end
        CHECK: begin
          cand_r <= 5'b00001;
          idx_r  <= 4'd0;
          if (rem_s == 5'd0) begin
            data_r     <= quo_s[7:0];
            unc_out_r  <= quo_s[8];
            corr_out_r <= corrected_r;
            pos_out_r  <= pos_r;
          end else if (corrected_r) begin
            data_r     <= quo_s[7:0];
            unc_out_r  <= 1'b1;
            corr_out_r <= 1'b0;
            pos_out_r  <= 4'd0;
          end
        end
        SEARCH: begin
          if (cand_r == rem_s) begin
            cw_r        <= cw_r ^ (14'd1 << idx_r);
            corrected_r <= 1'b1;
            pos_r       <= idx_r;
            cnt_r       <= 4'(BCH_N - 1);
          end else if (idx_r == 4'(BCH_N - 1)) begin
            data_r     <= quo_s[7:0];
            unc_out_r  <= 1'b1;
            corr_out_r <= 1'b0;
            pos_out_r  <= 4'd0;
          end else begin
            cand_r <= bch_mulx_mod(cand_r, 1'b0);
            idx_r  <= idx_r + 4'd1;
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bch_decoder.sv
// Directed self-checking bench for bch_decoder: vectors, latency, backpressure and reset abort.
module tb_bch_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_codeword;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_corrected;
  logic        out_uncorrectable;
  logic [3:0]  out_err_pos;

  int n_checks = 0;
  int n_fail   = 0;

  bch_decoder dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_codeword       (in_codeword),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .out_err_pos       (out_err_pos)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [13:0] cw);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("accept_ready", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_codeword = cw;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // returns cycles after the accept edge until out_valid is seen (0 = timeout)
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("busy_ready_low", 32'(in_ready), 32'd0);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 32'(in_ready), 32'd1);
    check_eq("idle_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_vec(input string tag, input logic [13:0] cw, input logic [7:0] ed,
                         input logic ec, input logic eu, input logic [3:0] ep, input int el);
    int lat;
    accept(cw);
    wait_valid(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(el));
    check_eq({tag, "_data"}, 32'(out_data), 32'(ed));
    check_eq({tag, "_corr"}, 32'(out_corrected), 32'(ec));
    check_eq({tag, "_unc"}, 32'(out_uncorrectable), 32'(eu));
    check_eq({tag, "_pos"}, 32'(out_err_pos), 32'(ep));
    release_out();
  endtask

  initial begin
    int lat;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_codeword = 14'd0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_corr", 32'(out_corrected), 32'd0);
    check_eq("rst_unc", 32'(out_uncorrectable), 32'd0);
    check_eq("rst_pos", 32'(out_err_pos), 32'd0);

    run_vec("noerr",  14'h1742, 8'hAA, 1'b0, 1'b0, 4'd0,  16);
    run_vec("err3",   14'h174A, 8'hAA, 1'b1, 1'b0, 4'd3,  35);
    run_vec("err13",  14'h3742, 8'hAA, 1'b1, 1'b0, 4'd13, 45);
    run_vec("err0",   14'h1743, 8'hAA, 1'b1, 1'b0, 4'd0,  32);
    run_vec("zero",   14'h0000, 8'h00, 1'b0, 1'b0, 4'd0,  16);
    run_vec("ones",   14'h1CE3, 8'hFF, 1'b0, 1'b0, 4'd0,  16);
    run_vec("double", 14'h1741, 8'hAA, 1'b0, 1'b1, 4'd0,  30);

    // backpressure: result must hold while in_valid pulses are ignored
    accept(14'h174A);
    wait_valid(lat);
    check_eq("stall_lat", 32'(lat), 32'd35);
    for (int k = 0; k < 10; k++) begin
      in_valid    = k[0];
      in_codeword = 14'h0000;
      @(negedge clk);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_data", 32'(out_data), 32'hAA);
      check_eq("stall_corr", 32'(out_corrected), 32'd1);
      check_eq("stall_unc", 32'(out_uncorrectable), 32'd0);
      check_eq("stall_pos", 32'(out_err_pos), 32'd3);
      check_eq("stall_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    repeat (20) @(negedge clk);
    check_eq("stall_no_capture", 32'(out_valid), 32'd0);

    // reset in the middle of a decode aborts it
    accept(14'h174A);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", 32'(in_ready), 32'd1);
    check_eq("abort_valid", 32'(out_valid), 32'd0);
    check_eq("abort_data", 32'(out_data), 32'd0);
    check_eq("abort_corr", 32'(out_corrected), 32'd0);
    check_eq("abort_unc", 32'(out_uncorrectable), 32'd0);
    check_eq("abort_pos", 32'(out_err_pos), 32'd0);
    repeat (40) @(negedge clk);
    check_eq("abort_no_output", 32'(out_valid), 32'd0);

    run_vec("after_rst", 14'h1742, 8'hAA, 1'b0, 1'b0, 4'd0, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
